// File: rtl/cfu_buf_pkg.sv
// cfu_buf_pkg: shared widths and CFU status-word error bit positions for accelerator buffers
package cfu_buf_pkg;
  localparam int DEPTH_DEF = 128;
  localparam int ADDR_W_DEF = $clog2(DEPTH_DEF);
  localparam int CNT_W_DEF = ADDR_W_DEF + 1;
  localparam int ERR_W = 2;
  localparam int ERR_OVF = 0;
  localparam int ERR_UDF = 1;
endpackage

// File: rtl/cfu_replay_buffer_if.sv
// cfu_replay_buffer_if: write/read/replay bus between CFU decoder, replay buffer and MAC feeder
interface cfu_replay_buffer_if import cfu_buf_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = ADDR_W_DEF
) ();
  logic clear;
  logic write_en;
  logic [DATA_W-1:0] write_data;
  logic write_ready;
  logic read_en;
  logic [DATA_W-1:0] read_data;
  logic read_valid;
  logic mark_set;
  logic mark_release;
  logic rewind;
  logic [ADDR_W:0] level;
  logic [ADDR_W:0] occupied;
  logic almost_full;
  logic almost_empty;
  logic overflow;
  logic underflow;
  modport master (
    output clear, write_en, write_data, read_en, mark_set, mark_release, rewind,
    input write_ready, read_data, read_valid, level, occupied, almost_full, almost_empty, overflow, underflow
  );
  modport slave (
    input clear, write_en, write_data, read_en, mark_set, mark_release, rewind,
    output write_ready, read_data, read_valid, level, occupied, almost_full, almost_empty, overflow, underflow
  );
endinterface

// File: rtl/cfu_sdp_ram.sv
// cfu_sdp_ram: simple dual-port block RAM, one write port and one registered read port, no array reset
module cfu_sdp_ram import cfu_buf_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int DEPTH = DEPTH_DEF,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end
  assign o_rdata = r_rdata;
endmodule

// File: rtl/cfu_replay_buffer.sv
// cfu_replay_buffer: FWFT block-RAM FIFO with watermarks, sticky errors and a mark/rewind replay window
module cfu_replay_buffer import cfu_buf_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int DEPTH = DEPTH_DEF,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int AF_LEVEL = DEPTH - 4,
  parameter int AE_LEVEL = 4
) (
  input logic clk,
  input logic rst,
  cfu_replay_buffer_if.slave bus
);
  localparam int CW = ADDR_W + 1;
  logic [ADDR_W-1:0] r_rd, r_wr, r_mark, w_fp, w_rd_n;
  logic [CW-1:0] r_lvl, r_occ, w_unf, w_lvl_n;
  logic [DATA_W-1:0] r_od, r_bd, w_q, w_s1;
  logic [ERR_W-1:0] r_err;
  logic r_pin, r_ov, r_sv, r_sb;
  logic w_rw, w_pop, w_push, w_set, w_rel, w_avail_ram, w_avail_push;
  logic w_ov_n, w_sv_n, w_sb_n, w_ld_s1, w_ld_wd, w_re, w_byp;
  assign w_rw = bus.rewind & r_pin;
  assign w_pop = bus.read_en & r_ov & !w_rw;
  assign w_push = bus.write_en & bus.write_ready;
  assign w_set = bus.mark_set & !w_rw;
  assign w_rel = bus.mark_release & !bus.mark_set & !w_rw;
  // pipeline holds words rd (output reg) and rd+1 (RAM stage); w_fp is the next word to fetch
  assign w_fp = r_rd + ADDR_W'(r_ov) + ADDR_W'(r_sv);
  assign w_unf = r_lvl - CW'(r_ov) - CW'(r_sv);
  assign w_avail_ram = w_unf != '0;
  assign w_avail_push = w_push & !w_avail_ram;
  assign w_s1 = r_sb ? r_bd : w_q;
  assign w_rd_n = w_rw ? r_mark : r_rd + ADDR_W'(w_pop);
  assign w_lvl_n = (w_rw ? r_occ : r_lvl - CW'(w_pop)) + CW'(w_push);
  always_comb begin
    w_ov_n = r_ov & !w_pop;
    w_sv_n = r_sv;
    w_sb_n = r_sb;
    w_ld_s1 = 1'b0;
    w_ld_wd = 1'b0;
    w_re = 1'b0;
    w_byp = 1'b0;
    if (w_rw) begin
      w_ov_n = 1'b0;
      w_sv_n = 1'b0;
    end else begin
      if (r_sv && (!r_ov || w_pop)) begin
        w_ld_s1 = 1'b1;
        w_ov_n = 1'b1;
        w_sv_n = 1'b0;
      end else if (w_pop && w_avail_push) begin
        w_ld_wd = 1'b1;
        w_ov_n = 1'b1;
      end
      // write-data bypass only once a word is in flight, so an empty buffer keeps its two-cycle latency
      if (!w_sv_n && w_avail_ram) begin
        w_re = 1'b1;
        w_sv_n = 1'b1;
        w_sb_n = 1'b0;
      end else if (!w_sv_n && w_avail_push && !w_ld_wd && (r_ov || r_sv)) begin
        w_byp = 1'b1;
        w_sv_n = 1'b1;
        w_sb_n = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst || bus.clear) begin
      r_rd <= '0;
      r_wr <= '0;
      r_mark <= '0;
      r_lvl <= '0;
      r_occ <= '0;
      r_pin <= 1'b0;
      r_ov <= 1'b0;
      r_sv <= 1'b0;
      r_sb <= 1'b0;
      r_od <= '0;
      r_bd <= '0;
      r_err <= '0;
    end else begin
      r_wr <= r_wr + ADDR_W'(w_push);
      r_rd <= w_rd_n;
      r_lvl <= w_lvl_n;
      r_ov <= w_ov_n;
      r_sv <= w_sv_n;
      r_sb <= w_sb_n;
      if (w_ld_s1) r_od <= w_s1;
      else if (w_ld_wd) r_od <= bus.write_data;
      if (w_byp) r_bd <= bus.write_data;
      if (w_set) begin
        r_pin <= 1'b1;
        r_mark <= r_rd;
        r_occ <= r_lvl + CW'(w_push);
      end else if (w_rel || !r_pin) begin
        r_pin <= 1'b0;
        r_mark <= w_rd_n;
        r_occ <= w_lvl_n;
      end else r_occ <= r_occ + CW'(w_push);
      r_err[ERR_OVF] <= r_err[ERR_OVF] | (bus.write_en & !bus.write_ready);
      r_err[ERR_UDF] <= r_err[ERR_UDF] | (bus.read_en & !r_ov & !w_rw);
    end
  end
  cfu_sdp_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
    .clk(clk),
    .i_we(w_push),
    .i_waddr(r_wr),
    .i_wdata(bus.write_data),
    .i_re(w_re),
    .i_raddr(w_fp),
    .o_rdata(w_q)
  );
  assign bus.read_data = r_od;
  assign bus.read_valid = r_ov;
  assign bus.level = r_lvl;
  assign bus.occupied = r_occ;
  assign bus.write_ready = r_occ < CW'(DEPTH);
  assign bus.almost_full = r_occ >= CW'(AF_LEVEL);
  assign bus.almost_empty = r_lvl <= CW'(AE_LEVEL);
  assign bus.overflow = r_err[ERR_OVF];
  assign bus.underflow = r_err[ERR_UDF];
endmodule

// File: doc/cfu_replay_buffer.md
# cfu_replay_buffer

Parametrised successor to the accelerator's input FIFO: a block-RAM FIFO with true first-word-fall-through reads, programmable watermarks, sticky error flags and a mark/rewind replay window. The replay window lets the convolution datapath re-read a tile of input words without the CPU re-sending them. It sits between the CFU instruction decoder (write side) and the MAC array feeder (read side).

## Interface
- DATA_W, 32: word width.
- DEPTH, 128: entries; power of two, minimum 4.
- ADDR_W, $clog2(DEPTH): pointer width; counts are ADDR_W+1 bits.
- AF_LEVEL, DEPTH-4: almost_full asserts when occupied ≥ AF_LEVEL.
- AE_LEVEL, 4: almost_empty asserts when level ≤ AE_LEVEL.

- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- clear  in  1  synchronous flush; same effect as rst, one cycle.
- write_en  in  1  push request.
- write_data  in  DATA_W  push word.
- write_ready  out  1  space available (occupied < DEPTH).
- read_en  in  1  pop request; acts only when read_valid is high.
- read_data  out  DATA_W  head word; valid while read_valid is high.
- read_valid  out  1  head word present.
- mark_set  in  1  pin the replay mark at the current head.
- mark_release  in  1  unpin; mark follows the read pointer again.
- rewind  in  1  move the read pointer back to the mark.
- level  out  ADDR_W+1  words not yet popped (wr − rd).
- occupied  out  ADDR_W+1  words retained (wr − mark).
- almost_full, almost_empty  out  1  watermark flags.
- overflow, underflow  out  1  sticky: push while full / pop while !read_valid.

## Operation
- Pointers rd, wr, mark, each ADDR_W bits, wrapping modulo DEPTH. Full/empty are decided on the ADDR_W+1-bit counts, never on pointer equality.
- Unpinned: mark tracks rd every cycle, so occupied == level.
- Pinned: mark is frozen. Entries from mark to wr are protected, and write_ready uses occupied.
- push = write_en & write_ready: mem[wr] ← data, wr+1.
- pop = read_en & read_valid & !rewind: rd+1.
- mark_set: mark ← rd value before this cycle's pop; pinned ← 1. If issued while already pinned, the mark is re-pinned at the new position.
- mark_release: pinned ← 0. If mark_set and mark_release are both asserted, mark_set wins.
- rewind:
  - pinned: rd ← mark; any pop request that cycle is ignored; pinned stays 1.
  - unpinned: no-op.
  - rewind wins over mark_set in the same cycle.
- Priority: rst > clear > rewind > mark_set > mark_release. Push is independent of all of these, except rst and clear.
- Simultaneous push and pop: both act; level is unchanged.
- Push while full sets overflow and leaves the data dropped and state unchanged. Pop while !read_valid sets underflow and leaves state unchanged.
- Sticky flags clear only on rst or clear.
- Reset and clear values:
  - all pointers = 0, pinned = 0
  - read_valid = 0, read_data = 0
  - level = occupied = 0
  - write_ready = 1, almost_empty = 1, almost_full = 0
  - overflow = underflow = 0
- rst mid-transfer discards all contents immediately, asynchronously.

## Timing
- RAM read latency is 1 cycle, plus an output register. read_data and read_valid are registered outputs.
- Write into an empty buffer at edge k: read_valid = 1 and read_data = that word after edge k+2.
- Sustained throughput is one pop per cycle with no bubbles while level ≥ 2. A pop at edge k presents the next word after edge k, with no gap.
- After a rewind at edge k: read_valid = 0 for the cycles following edges k and k+1. The marked word appears after edge k+2.
- level, occupied, write_ready and the watermark flags are combinational from the registered counts. They reflect all pushes and pops up to the last edge.
- A pop frees space only when unpinned. When pinned, space frees only on mark_release or on re-pinning at a later position.

## Structure
- Shared package cfu_buf_pkg holds:
  - the width helper localparams (ADDR_W derivation, count width);
  - the error-flag bit indices for the CFU status word.
- Sub-module cfu_sdp_ram: DATA_W × DEPTH simple dual-port block RAM.
  - One write port and one registered read port.
  - No reset on the array.
  - Reused by later accelerator buffers.
- Top level holds the pointer logic, counts, the prefetch/output register and the flags.

## Test plan
- Reset then push 0xA0..0xA3 on consecutive cycles:
  - first word visible on read_data with read_valid = 1 two cycles after the first push;
  - continuous pops return A0, A1, A2, A3 back-to-back;
  - level ends at 0 and almost_empty = 1.
- Fill DEPTH=128 unpinned:
  - write_ready drops after the 128th push;
  - almost_full asserts at occupied = 124;
  - a 129th push sets overflow and leaves level = 128;
  - one pop restores write_ready.
- Push 8 words, mark_set, pop 5 (level = 3, occupied = 8), rewind:
  - read_valid low for 2 cycles;
  - next pops return the words at the mark, in order;
  - a push attempt when occupied = 128 is refused even though level < 128.
- Simultaneous push and pop at level = 1 for 100 cycles: level stays 1, data order preserved across pointer wrap-around.
- Pop with read_valid = 0 sets underflow; rewind while unpinned is a no-op; clear resets both sticky flags and all counts to 0.
- Assert rst asynchronously mid-burst (between edges): all outputs take reset values immediately and no stale word appears after release.
